// File: rtl/riscv_cache_pkg.sv
// Cache geometry helpers shared by the cache pipeline stages.
package riscv_cache_pkg;

  // Number of sets for a cache of cache_kb kilobytes with block_bits-wide blocks.
  function automatic int unsigned no_of_sets(input int unsigned cache_kb,
                                             input int unsigned block_bits,
                                             input int unsigned ways);
    return (cache_kb * 1024 * 8) / (block_bits * ways);
  endfunction

  // Index width needed to address every set; never narrower than one bit.
  function automatic int unsigned no_of_index_bits(input int unsigned sets);
    return (sets > 1) ? $clog2(sets) : 1;
  endfunction

endpackage

// File: rtl/riscv_cache_writebuffer.sv
// Cache write buffer: queues committed stores per set/way, merges back-to-back
// stores to the same word, drains into the data memory write port when it is
// free and forwards buffered bytes to loads.
module riscv_cache_writebuffer
  import riscv_cache_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SIZE       = 64,
  parameter int unsigned BLOCK_SIZE = XLEN,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned IDX_BITS  = no_of_index_bits(no_of_sets(SIZE, BLOCK_SIZE, WAYS))
) (
  input  logic                  rst_ni,
  input  logic                  clk_i,
  // Store commit from the address setup stage
  input  logic                  wb_we_i,
  input  logic [WAYS-1:0]       wb_way_i,
  input  logic [IDX_BITS-1:0]   wb_idx_i,
  input  logic [XLEN-1:0]       wb_data_i,
  input  logic [XLEN/8-1:0]     wb_be_i,
  output logic                  full_o,
  output logic                  empty_o,
  // Data memory write port
  input  logic                  mem_rdy_i,
  output logic                  mem_we_o,
  output logic [WAYS-1:0]       mem_way_o,
  output logic [IDX_BITS-1:0]   mem_idx_o,
  output logic [XLEN-1:0]       mem_data_o,
  output logic [XLEN/8-1:0]     mem_be_o,
  // Load forwarding lookup
  input  logic [IDX_BITS-1:0]   rd_idx_i,
  input  logic [WAYS-1:0]       rd_way_i,
  output logic [XLEN/8-1:0]     fwd_be_o,
  output logic [XLEN-1:0]       fwd_data_o
);

  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [IDX_BITS-1:0] idx;
    logic [WAYS-1:0]     way;
    logic [XLEN-1:0]     data;
    logic [BE_W-1:0]     be;
  } wb_entry_t;

  // Overlay the enabled bytes of new_data onto old_data.
  function automatic logic [XLEN-1:0] byte_merge(input logic [XLEN-1:0] old_data,
                                                 input logic [XLEN-1:0] new_data,
                                                 input logic [BE_W-1:0] be);
    logic [XLEN-1:0] res;
    res = old_data;
    for (int unsigned b = 0; b < BE_W; b++) begin
      if (be[b]) res[8*b +: 8] = new_data[8*b +: 8];
    end
    return res;
  endfunction

  wb_entry_t          entry_q [DEPTH];
  wb_entry_t          entry_d [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               empty, full, push, pop, merge, alloc;
  logic [PTR_W-1:0]   tail_ptr;
  wb_entry_t          head, tail;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign push     = wb_we_i & (|wb_way_i);
  assign pop      = ~empty & mem_rdy_i;
  assign tail_ptr = wr_ptr_q - PTR_W'(1);
  assign head     = entry_q[rd_ptr_q];
  assign tail     = entry_q[tail_ptr];

  // A lone entry that is draining this cycle cannot absorb a merge; the store
  // would be lost with the popped entry, so it allocates instead.
  assign merge = push & ~empty &
                 (tail.idx == wb_idx_i) & (tail.way == wb_way_i) &
                 ~((count_q == CNT_W'(1)) & pop);

  // A full buffer only accepts a new entry when the head frees a slot this cycle.
  assign alloc = push & ~merge & (~full | pop);

  assign full_o  = full;
  assign empty_o = empty;

  // Drain port follows the head entry combinationally.
  assign mem_we_o   = pop;
  assign mem_way_o  = head.way;
  assign mem_idx_o  = head.idx;
  assign mem_data_o = head.data;
  assign mem_be_o   = head.be;

  // Next-state for entries, pointers and occupancy.
  always_comb begin
    entry_d  = entry_q;
    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end

    // Allocation after the pop so a full-buffer push can reuse the freed slot.
    if (merge) begin
      entry_d[tail_ptr].data = byte_merge(tail.data, wb_data_i, wb_be_i);
      entry_d[tail_ptr].be   = tail.be | wb_be_i;
    end else if (alloc) begin
      entry_d[wr_ptr_q].idx  = wb_idx_i;
      entry_d[wr_ptr_q].way  = wb_way_i;
      entry_d[wr_ptr_q].data = wb_data_i;
      entry_d[wr_ptr_q].be   = wb_be_i;
      valid_d[wr_ptr_q]      = 1'b1;
      wr_ptr_d               = wr_ptr_q + PTR_W'(1);
    end

    unique case ({alloc, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload; qualified by valid_q so it needs no reset.
  always_ff @(posedge clk_i) begin
    entry_q <= entry_d;
  end

  // Forwarding: walk entries oldest to youngest so younger bytes overwrite older.
  always_comb begin
    logic [PTR_W-1:0] k;
    k          = '0;
    fwd_be_o   = '0;
    fwd_data_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      k = rd_ptr_q + PTR_W'(i);
      if (valid_q[k] && (entry_q[k].idx == rd_idx_i) && (entry_q[k].way == rd_way_i)) begin
        fwd_data_o = byte_merge(fwd_data_o, entry_q[k].data, entry_q[k].be);
        fwd_be_o   = fwd_be_o | entry_q[k].be;
      end
    end
  end

endmodule

// File: tb/tb_riscv_cache_writebuffer.sv
// Scoreboard bench for the cache write buffer: the driver applies stores to a
// queue model of the buffer contents, the monitor checks flags, forwarding and
// every memory write against that queue.
module tb_riscv_cache_writebuffer;
  import riscv_cache_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SIZE  = 64;
  localparam int unsigned WAYS  = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDX   = no_of_index_bits(no_of_sets(SIZE, XLEN, WAYS));
  localparam int unsigned BEW   = XLEN / 8;

  typedef struct {
    logic [IDX-1:0]  idx;
    logic [WAYS-1:0] way;
    logic [XLEN-1:0] data;
    logic [BEW-1:0]  be;
  } ent_t;

  logic            rst_ni, clk_i;
  logic            wb_we_i;
  logic [WAYS-1:0] wb_way_i;
  logic [IDX-1:0]  wb_idx_i;
  logic [XLEN-1:0] wb_data_i;
  logic [BEW-1:0]  wb_be_i;
  logic            full_o, empty_o;
  logic            mem_rdy_i, mem_we_o;
  logic [WAYS-1:0] mem_way_o;
  logic [IDX-1:0]  mem_idx_o;
  logic [XLEN-1:0] mem_data_o;
  logic [BEW-1:0]  mem_be_o;
  logic [IDX-1:0]  rd_idx_i;
  logic [WAYS-1:0] rd_way_i;
  logic [BEW-1:0]  fwd_be_o;
  logic [XLEN-1:0] fwd_data_o;

  int   checks   = 0;
  int   failures = 0;
  ent_t sb[$];

  riscv_cache_writebuffer #(
    .XLEN(XLEN), .SIZE(SIZE), .BLOCK_SIZE(XLEN), .WAYS(WAYS), .DEPTH(DEPTH)
  ) dut (
    .rst_ni(rst_ni), .clk_i(clk_i),
    .wb_we_i(wb_we_i), .wb_way_i(wb_way_i), .wb_idx_i(wb_idx_i),
    .wb_data_i(wb_data_i), .wb_be_i(wb_be_i),
    .full_o(full_o), .empty_o(empty_o),
    .mem_rdy_i(mem_rdy_i), .mem_we_o(mem_we_o), .mem_way_o(mem_way_o),
    .mem_idx_o(mem_idx_o), .mem_data_o(mem_data_o), .mem_be_o(mem_be_o),
    .rd_idx_i(rd_idx_i), .rd_way_i(rd_way_i),
    .fwd_be_o(fwd_be_o), .fwd_data_o(fwd_data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] be_mask(input logic [BEW-1:0] be);
    logic [XLEN-1:0] m;
    m = '0;
    for (int b = 0; b < BEW; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  // Monitor: compares outputs against the model at the falling edge.
  always @(negedge clk_i) begin
    logic            e_pop;
    logic [BEW-1:0]  e_be;
    logic [XLEN-1:0] e_data, m;
    ent_t            h;
    if (!rst_ni) begin
      chk("rst_empty", empty_o, 1);
      chk("rst_full", full_o, 0);
      chk("rst_mem_we", mem_we_o, 0);
      chk("rst_fwd_be", fwd_be_o, 0);
      sb.delete();
    end else begin
      e_pop = mem_rdy_i && (sb.size() > 0);
      chk("empty", empty_o, sb.size() == 0);
      chk("full", full_o, sb.size() == DEPTH);
      chk("mem_we", mem_we_o, e_pop);
      e_be   = '0;
      e_data = '0;
      foreach (sb[i]) begin
        if (sb[i].idx == rd_idx_i && sb[i].way == rd_way_i) begin
          for (int b = 0; b < BEW; b++) begin
            if (sb[i].be[b]) begin
              e_data[8*b +: 8] = sb[i].data[8*b +: 8];
              e_be[b]          = 1'b1;
            end
          end
        end
      end
      chk("fwd_be", fwd_be_o, e_be);
      chk("fwd_data", fwd_data_o & be_mask(e_be), e_data);
      if (sb.size() > 0 && (e_pop || mem_we_o)) begin
        h = sb.pop_front();
        m = be_mask(h.be);
        chk("mem_idx", mem_idx_o, h.idx);
        chk("mem_way", mem_way_o, h.way);
        chk("mem_be", mem_be_o, h.be);
        chk("mem_data", mem_data_o & m, h.data & m);
      end
    end
  end

  // Drive one cycle of stimulus, then fold the store into the model after the
  // monitor has retired this cycle's drain.
  task automatic drive(input logic we, input logic [WAYS-1:0] way, input logic [IDX-1:0] idx,
                       input logic [XLEN-1:0] data, input logic [BEW-1:0] be, input logic rdy,
                       input logic [IDX-1:0] ridx, input logic [WAYS-1:0] rway);
    int   sz_after;
    bit   mrg;
    ent_t e;
    @(posedge clk_i);
    #2;
    sz_after = sb.size() - ((rdy && sb.size() > 0) ? 1 : 0);
    mrg = we && (way != '0) && (sz_after > 0) && sb[$].idx == idx && sb[$].way == way;
    // Never issue a store the buffer would have to drop.
    if (we && way != '0 && !mrg && sz_after >= DEPTH) we = 1'b0;
    wb_we_i   = we;
    wb_way_i  = way;
    wb_idx_i  = idx;
    wb_data_i = data;
    wb_be_i   = be;
    mem_rdy_i = rdy;
    rd_idx_i  = ridx;
    rd_way_i  = rway;
    @(negedge clk_i);
    #1;
    if (rst_ni && we && way != '0) begin
      if (sb.size() > 0 && sb[$].idx == idx && sb[$].way == way) begin
        for (int b = 0; b < BEW; b++) if (be[b]) sb[$].data[8*b +: 8] = data[8*b +: 8];
        sb[$].be = sb[$].be | be;
      end else begin
        e.idx = idx; e.way = way; e.data = data; e.be = be;
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic rdy, input logic [IDX-1:0] ridx, input logic [WAYS-1:0] rway);
    drive(1'b0, '0, '0, '0, '0, rdy, ridx, rway);
  endtask

  task automatic set_rst(input logic v);
    @(posedge clk_i);
    #2;
    rst_ni  = v;
    wb_we_i = 1'b0;
  endtask

  function automatic logic [WAYS-1:0] rand_way();
    int r;
    r = $urandom_range(0, 9);
    return (r == 0) ? 2'b00 : (r < 5) ? 2'b01 : 2'b10;
  endfunction

  initial begin
    logic [IDX-1:0]  ridx;
    logic [WAYS-1:0] rway;
    int              prob;
    ent_t            pick;
    rst_ni = 1'b0; wb_we_i = 1'b0; wb_way_i = '0; wb_idx_i = '0; wb_data_i = '0;
    wb_be_i = '0; mem_rdy_i = 1'b0; rd_idx_i = '0; rd_way_i = '0;
    repeat (2) @(posedge clk_i);
    set_rst(1'b1);

    // Single store, held then drained.
    drive(1'b1, 2'b01, 13'd3, 32'hAABBCCDD, 4'hF, 1'b0, 13'd3, 2'b01);
    idle(1'b0, 13'd3, 2'b01);
    idle(1'b1, 13'd3, 2'b01);
    idle(1'b1, 13'd3, 2'b01);

    // Merge of two partial stores into one entry.
    drive(1'b1, 2'b01, 13'd5, 32'h00000011, 4'h1, 1'b0, 13'd5, 2'b01);
    drive(1'b1, 2'b01, 13'd5, 32'h00330000, 4'h4, 1'b0, 13'd5, 2'b01);
    idle(1'b0, 13'd5, 2'b01);
    idle(1'b1, 13'd5, 2'b01);
    idle(1'b1, 13'd5, 2'b01);

    // Fill, then push into the slot freed by a same-cycle drain.
    for (int i = 0; i < 4; i++)
      drive(1'b1, 2'b10, IDX'(10 + i), 32'h1000 + i, 4'hF, 1'b0, 13'd0, 2'b01);
    drive(1'b1, 2'b10, 13'd14, 32'h2222_0000, 4'hF, 1'b1, 13'd12, 2'b10);
    idle(1'b0, 13'd14, 2'b10);
    repeat (6) idle(1'b1, 13'd0, 2'b00);

    // Forwarding across a non-matching entry in between.
    drive(1'b1, 2'b01, 13'd7, 32'h0000BEEF, 4'h3, 1'b0, 13'd7, 2'b01);
    drive(1'b1, 2'b01, 13'd9, 32'h12345678, 4'hF, 1'b0, 13'd7, 2'b01);
    drive(1'b1, 2'b01, 13'd7, 32'h0000AA00, 4'h2, 1'b0, 13'd7, 2'b01);
    idle(1'b0, 13'd7, 2'b01);
    idle(1'b0, 13'd7, 2'b10);
    repeat (5) idle(1'b1, 13'd7, 2'b01);

    // Miss is ignored; lone draining entry cannot absorb a same-index store.
    drive(1'b1, 2'b00, 13'd20, 32'hDEADBEEF, 4'hF, 1'b0, 13'd20, 2'b01);
    idle(1'b0, 13'd20, 2'b01);
    drive(1'b1, 2'b01, 13'd20, 32'h000000AA, 4'h1, 1'b0, 13'd20, 2'b01);
    drive(1'b1, 2'b01, 13'd20, 32'h0000BB00, 4'h2, 1'b1, 13'd20, 2'b01);
    repeat (3) idle(1'b1, 13'd20, 2'b01);

    // Reset in the middle of a drain.
    for (int i = 0; i < 3; i++)
      drive(1'b1, 2'b01, IDX'(30 + i), 32'h3000 + i, 4'hF, 1'b0, 13'd31, 2'b01);
    idle(1'b1, 13'd31, 2'b01);
    set_rst(1'b0);
    idle(1'b1, 13'd31, 2'b01);
    set_rst(1'b1);
    repeat (3) idle(1'b1, 13'd31, 2'b01);

    // Randomized traffic with varying drain availability.
    for (int n = 0; n < 800; n++) begin
      case ((n / 100) % 4)
        0:       prob = 20;
        1:       prob = 50;
        2:       prob = 90;
        default: prob = 0;
      endcase
      if (sb.size() > 0 && $urandom_range(0, 1) == 1) begin
        pick = sb[$urandom_range(0, sb.size() - 1)];
        ridx = pick.idx;
        rway = pick.way;
      end else begin
        ridx = IDX'($urandom_range(0, 7));
        rway = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
      end
      drive($urandom_range(0, 2) != 0, rand_way(), IDX'($urandom_range(0, 7)), $urandom,
            BEW'($urandom_range(0, 15)), $urandom_range(0, 99) < prob, ridx, rway);
    end
    repeat (DEPTH + 4) idle(1'b1, 13'd0, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
